regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with a scoreboard, the next generation of the CPU datapath's 8×16 register file. It adds configurable data width, depth and read-port count, optional write-to-read bypass, a hardwired-zero register option, an asynchronous clear of all state, and a per-register pending (scoreboard) bit that the issue logic uses to detect read-after-write hazards. It sits between decode/issue, which reads and reserves, and writeback, which writes and releases.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reservations
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rd_busy  out  NUM_RD  port i source is pending, so its data is not yet valid
- rsv_en  in  1  reserve: mark register rsv_addr pending (issue)
- rsv_addr  in  ADDR_W  register to reserve
- pending  out  DEPTH  scoreboard bit vector, registered
- dbg_sel  in  ADDR_W  debug/display register select
- dbg_data  out  DATA_W  architectural value of dbg_sel, with no bypass

## Operation
- Storage: DEPTH×DATA_W flops plus a DEPTH-bit pending vector.
- Reset (rst=1, asynchronous): every register and every pending bit clears to 0. While reset is held, rdata and dbg_data read 0, rd_busy=0 and pending=0.
- Write: on a rising edge with we=1, regs[waddr] <= wdata and pending[waddr] <= 0. With ZERO_REG=1 and waddr=0, the write is dropped.
- Reserve: on a rising edge with rsv_en=1, pending[rsv_addr] <= 1. With ZERO_REG=1 and rsv_addr=0, the reservation is ignored.
- Simultaneous write and reserve to the same address: the data is written and pending ends at 1, because the reservation belongs to a newer producer.
- Simultaneous write and reserve to different addresses: both take effect.
- Read port i, with a = raddr slice i:
  - ZERO_REG=1 and a=0: rdata 0, rd_busy 0.
  - BYPASS=1, we=1 and waddr=a (writable): rdata = wdata and rd_busy = 0.
  - Otherwise: rdata = regs[a] and rd_busy = pending[a].
- Several ports may name the same address; each resolves independently.
- dbg_data = regs[dbg_sel], or 0 for register 0 when ZERO_REG=1. It never bypasses.
- BYPASS=0: reads see the old value until the edge after the write, and rd_busy follows pending[a] directly.

## Timing
- Write latency is one edge; with BYPASS=1, the effective read latency is zero.
- Reserve latency is one edge; pending and rd_busy rise the cycle after rsv_en.
- rdata and rd_busy are purely combinational from raddr, we, waddr, wdata and the state.
- Reset is asserted asynchronously and must be released synchronously by the reset source. The first write can occur on the first edge after rst falls.
- rst asserted mid-operation: in-flight writes and reservations on that edge are lost, and all state returns to 0.

## Structure
- Shared package regfile_pkg holds:
  - the default DATA_W and ADDR_W constants;
  - a function that unpacks a port slice;
  - the ZERO_REG address constant (0).
- One sub-module, regfile_rdport, contains the per-port read mux, zero check and bypass compare, instantiated NUM_RD times in a generate loop. The storage and scoreboard live in the top level.

## Test plan
- Reset/zero: set rst=1 and then release it; read all addresses on every port -> rdata = 0, pending = 0. Write 0xBEEF to register 0 -> it still reads 0 and pending[0] = 0.
- Write/read with bypass: write 0x1234 to r3 while raddr0 = 3 -> rdata0 = 0x1234 in the same cycle. The next cycle, with we=0 -> still 0x1234. Repeat with BYPASS=0 -> the old value (0) in the write cycle and 0x1234 after.
- Scoreboard: reserve r5 -> after one edge, pending[5] = 1 and rd_busy1 = 1 with raddr1 = 5. Write 0x00AA to r5 -> bypassed read gives rdata1 = 0x00AA and rd_busy1 = 0 that cycle, and pending[5] = 0 after the edge.
- Same-edge write and reserve to r2 -> regs[2] = wdata and pending[2] = 1. Same edge, write r2 and reserve r4 -> pending[2] = 0 and pending[4] = 1.
- Async reset mid-stream: fill all registers with random data and reserve r6, then pulse rst between clock edges -> all registers read 0 immediately and pending = 0.
- Parameter sweep: DATA_W = 32, ADDR_W = 5, NUM_RD = 3, ZERO_REG = 0 -> r0 is writable. Three ports reading the same address all return the same value. dbg_data matches a reference model over 1000 random write/reserve/read cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Pure declarations; no logic, no latency, no backpressure.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int ZERO_ADDR  = 0;

  // Low bit of port `port` inside a packed per-port bus of `width`-bit fields.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback bundle for regfile_sb; the master is the pipeline, the slave is the register file.
// No handshake: every field is sampled or produced each cycle.
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DEPTH-1:0]         pending;
  logic [ADDR_W-1:0]        dbg_sel;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output we, waddr, wdata, raddr, rsv_en, rsv_addr, dbg_sel,
    input  rdata, rd_busy, pending, dbg_data
  );

  modport slave (
    input  we, waddr, wdata, raddr, rsv_en, rsv_addr, dbg_sel,
    output rdata, rd_busy, pending, dbg_data
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register check, write bypass, then array/scoreboard lookup.
// Zero latency; never stalls, reports a pending source through rd_busy instead.
module regfile_rdport import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]    raddr,
  input  logic                 fwd_vld,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W-1:0]    regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] pending,
  output logic [DATA_W-1:0]    rdata,
  output logic                 rd_busy
);

  always_comb begin
    rdata   = regs[raddr];
    rd_busy = pending[raddr];
    if (BYPASS && fwd_vld && (waddr == raddr)) begin
      rdata   = wdata;
      rd_busy = 1'b0;
    end
    // Checked last so a forwarded write to r0 can never leak through.
    if (ZERO_REG && (raddr == ADDR_W'(ZERO_ADDR))) begin
      rdata   = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with per-register pending scoreboard and NUM_RD bypassing read ports.
// Writes/reservations take one edge, reads are combinational; no backpressure.
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok;
  logic              rsv_ok;
  logic              fwd_vld;

  assign wr_ok  = bus.we     && !(ZERO_REG && (bus.waddr    == ADDR_W'(ZERO_ADDR)));
  assign rsv_ok = bus.rsv_en && !(ZERO_REG && (bus.rsv_addr == ADDR_W'(ZERO_ADDR)));
  // Held reset must read as all-zero, so forwarding is suppressed too.
  assign fwd_vld = bus.we && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Reserve is applied after release so a same-address pair ends pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (wr_ok)  pend[bus.waddr]    <= 1'b0;
      if (rsv_ok) pend[bus.rsv_addr] <= 1'b1;
    end
  end

  assign bus.pending  = pend;
  assign bus.dbg_data = (ZERO_REG && (bus.dbg_sel == ADDR_W'(ZERO_ADDR))) ? '0 : regs[bus.dbg_sel];

  logic [NUM_RD*DATA_W-1:0] rdata_w;
  logic [NUM_RD-1:0]        busy_w;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .raddr  (bus.raddr[slice_lo(i, ADDR_W) +: ADDR_W]),
      .fwd_vld(fwd_vld),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .regs   (regs),
      .pending(pend),
      .rdata  (rdata_w[slice_lo(i, DATA_W) +: DATA_W]),
      .rd_busy(busy_w[i])
    );
  end

  assign bus.rdata   = rdata_w;
  assign bus.rd_busy = busy_w;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default config, a no-bypass copy, and a wide 3-port config with a reference model.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) ifa ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) ifb ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) ifc ();

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.we = 1'b0; ifa.waddr = '0; ifa.wdata = '0; ifa.raddr = '0;
    ifa.rsv_en = 1'b0; ifa.rsv_addr = '0; ifa.dbg_sel = '0;
    ifb.we = 1'b0; ifb.waddr = '0; ifb.wdata = '0; ifb.raddr = '0;
    ifb.rsv_en = 1'b0; ifb.rsv_addr = '0; ifb.dbg_sel = '0;
    ifc.we = 1'b0; ifc.waddr = '0; ifc.wdata = '0; ifc.raddr = '0;
    ifc.rsv_en = 1'b0; ifc.rsv_addr = '0; ifc.dbg_sel = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    ifa.we = 1'b1; ifa.waddr = 3'd3; ifa.wdata = 16'hFFFF; ifa.raddr = {3'd3, 3'd3};
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd3;
    #1;
    n_chk++;
    if ({ifa.rdata, ifa.rd_busy, ifa.pending} !== '0)
      $display("FAIL reset_held_outputs: got rdata=%h busy=%b pending=%b, want all 0",
               ifa.rdata, ifa.rd_busy, ifa.pending);
    else n_pass++;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      ifa.raddr = {3'(i), 3'(i)};
      #1;
      n_chk++;
      if ({ifa.rdata, ifa.rd_busy} !== '0)
        $display("FAIL reset_read_r%0d: got rdata=%h busy=%b, want 0", i, ifa.rdata, ifa.rd_busy);
      else n_pass++;
    end
    ifa.dbg_sel = 3'd3;
    #1;
    n_chk++;
    if ({ifa.pending, ifa.dbg_data} !== '0)
      $display("FAIL reset_lost_write: got pending=%b dbg=%h, want 0", ifa.pending, ifa.dbg_data);
    else n_pass++;

    tick();
    idle();
    ifa.we = 1'b1; ifa.waddr = 3'd0; ifa.wdata = 16'hBEEF;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd0; ifa.raddr = {3'd0, 3'd0};
    #1;
    n_chk++;
    if ({ifa.rdata, ifa.rd_busy} !== '0)
      $display("FAIL zero_reg_bypass: got rdata=%h busy=%b, want 0", ifa.rdata, ifa.rd_busy);
    else n_pass++;
    tick();
    idle();
    #1;
    n_chk++;
    if ({ifa.pending, ifa.dbg_data, ifa.rdata} !== '0)
      $display("FAIL zero_reg_write: got pending=%b dbg=%h rdata=%h, want 0",
               ifa.pending, ifa.dbg_data, ifa.rdata);
    else n_pass++;
  endtask

  task automatic test_bypass();
    tick();
    idle();
    ifa.we = 1'b1; ifa.waddr = 3'd3; ifa.wdata = 16'h1234; ifa.raddr = {3'd0, 3'd3};
    ifb.we = 1'b1; ifb.waddr = 3'd3; ifb.wdata = 16'h1234; ifb.raddr = {3'd0, 3'd3};
    #1;
    n_chk++;
    if ({ifa.rdata[15:0], ifa.rd_busy[0]} !== {16'h1234, 1'b0})
      $display("FAIL bypass_same_cycle: got %h busy=%b, want 1234 busy=0", ifa.rdata[15:0], ifa.rd_busy[0]);
    else n_pass++;
    n_chk++;
    if (ifb.rdata[15:0] !== 16'h0000)
      $display("FAIL nobypass_same_cycle: got %h, want 0000", ifb.rdata[15:0]);
    else n_pass++;
    tick();
    ifa.we = 1'b0;
    ifb.we = 1'b0;
    #1;
    n_chk++;
    if (ifa.rdata[15:0] !== 16'h1234)
      $display("FAIL bypass_next_cycle: got %h, want 1234", ifa.rdata[15:0]);
    else n_pass++;
    n_chk++;
    if (ifb.rdata[15:0] !== 16'h1234)
      $display("FAIL nobypass_next_cycle: got %h, want 1234", ifb.rdata[15:0]);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    tick();
    idle();
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd5; ifa.raddr = {3'd5, 3'd3};
    ifb.rsv_en = 1'b1; ifb.rsv_addr = 3'd5; ifb.raddr = {3'd5, 3'd3};
    #1;
    n_chk++;
    if (ifa.rd_busy !== 2'b00)
      $display("FAIL reserve_not_early: got busy=%b, want 00", ifa.rd_busy);
    else n_pass++;
    tick();
    ifa.rsv_en = 1'b0;
    ifb.rsv_en = 1'b0;
    #1;
    n_chk++;
    if ({ifa.pending, ifa.rd_busy} !== {8'h20, 2'b10})
      $display("FAIL reserve_r5: got pending=%b busy=%b, want 00100000 10", ifa.pending, ifa.rd_busy);
    else n_pass++;
    ifa.we = 1'b1; ifa.waddr = 3'd5; ifa.wdata = 16'h00AA;
    ifb.we = 1'b1; ifb.waddr = 3'd5; ifb.wdata = 16'h00AA;
    #1;
    n_chk++;
    if ({ifa.rdata[31:16], ifa.rd_busy} !== {16'h00AA, 2'b00})
      $display("FAIL release_bypass: got %h busy=%b, want 00aa 00", ifa.rdata[31:16], ifa.rd_busy);
    else n_pass++;
    n_chk++;
    if ({ifb.rdata[31:16], ifb.rd_busy} !== {16'h0000, 2'b10})
      $display("FAIL release_nobypass: got %h busy=%b, want 0000 10", ifb.rdata[31:16], ifb.rd_busy);
    else n_pass++;
    tick();
    ifa.we = 1'b0;
    ifb.we = 1'b0;
    #1;
    n_chk++;
    if ({ifa.pending, ifa.rdata[31:16]} !== {8'h00, 16'h00AA})
      $display("FAIL release_after: got pending=%b data=%h, want 0 00aa", ifa.pending, ifa.rdata[31:16]);
    else n_pass++;
    n_chk++;
    if ({ifb.pending, ifb.rd_busy, ifb.rdata[31:16]} !== {8'h00, 2'b00, 16'h00AA})
      $display("FAIL release_after_nobypass: got pending=%b busy=%b data=%h, want 0 00 00aa",
               ifb.pending, ifb.rd_busy, ifb.rdata[31:16]);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    tick();
    idle();
    ifa.we = 1'b1; ifa.waddr = 3'd2; ifa.wdata = 16'h5A5A;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd2;
    tick();
    idle();
    ifa.dbg_sel = 3'd2;
    #1;
    n_chk++;
    if ({ifa.dbg_data, ifa.pending} !== {16'h5A5A, 8'h04})
      $display("FAIL same_addr_wr_rsv: got data=%h pending=%b, want 5a5a 00000100", ifa.dbg_data, ifa.pending);
    else n_pass++;
    ifa.we = 1'b1; ifa.waddr = 3'd2; ifa.wdata = 16'h0102;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd4;
    tick();
    idle();
    ifa.dbg_sel = 3'd2;
    #1;
    n_chk++;
    if ({ifa.dbg_data, ifa.pending} !== {16'h0102, 8'h10})
      $display("FAIL diff_addr_wr_rsv: got data=%h pending=%b, want 0102 00010000", ifa.dbg_data, ifa.pending);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [15:0] model [8];
    logic [31:0] rnd;
    model[0] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      idle();
      rnd = $urandom;
      ifa.we = 1'b1; ifa.waddr = 3'(i); ifa.wdata = rnd[15:0] | 16'h0001;
      if (i != 0) model[i] = rnd[15:0] | 16'h0001;
      if (i == 7) begin ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd6; end
    end
    tick();
    idle();
    ifa.dbg_sel = 3'd7;
    #1;
    n_chk++;
    if ({ifa.dbg_data, ifa.pending} !== {model[7], 8'h40})
      $display("FAIL fill_before_reset: got data=%h pending=%b, want %h 01000000",
               ifa.dbg_data, ifa.pending, model[7]);
    else n_pass++;
    ifa.raddr = {3'd6, 3'd7};
    #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ifa.pending, ifa.rd_busy, ifa.rdata} !== '0)
      $display("FAIL async_reset_immediate: got pending=%b busy=%b rdata=%h, want 0",
               ifa.pending, ifa.rd_busy, ifa.rdata);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      ifa.dbg_sel = 3'(i);
      #1;
      n_chk++;
      if (ifa.dbg_data !== 16'h0000)
        $display("FAIL async_reset_r%0d: got %h, want 0000", i, ifa.dbg_data);
      else n_pass++;
    end
    ifa.we = 1'b1; ifa.waddr = 3'd1; ifa.wdata = 16'hFFFF;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd1;
    tick();
    tick();
    rst = 1'b0;
    idle();
    ifa.dbg_sel = 3'd1;
    #1;
    n_chk++;
    if ({ifa.dbg_data, ifa.pending} !== '0)
      $display("FAIL write_during_reset: got data=%h pending=%b, want 0", ifa.dbg_data, ifa.pending);
    else n_pass++;
    ifa.we = 1'b1; ifa.waddr = 3'd1; ifa.wdata = 16'h7777;
    tick();
    idle();
    ifa.dbg_sel = 3'd1;
    #1;
    n_chk++;
    if (ifa.dbg_data !== 16'h7777)
      $display("FAIL first_write_after_reset: got %h, want 7777", ifa.dbg_data);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [4:0]  ra [3];
    logic [95:0] exp_rd;
    logic [2:0]  exp_busy;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend = '0;

    tick();
    idle();
    ifc.we = 1'b1; ifc.waddr = 5'd0; ifc.wdata = 32'hDEADBEEF; ifc.raddr = '0;
    #1;
    n_chk++;
    if (ifc.rdata !== {3{32'hDEADBEEF}})
      $display("FAIL sweep_r0_bypass: got %h, want 3x deadbeef", ifc.rdata);
    else n_pass++;
    tick();
    idle();
    m_regs[0] = 32'hDEADBEEF;
    #1;
    n_chk++;
    if ({ifc.rdata, ifc.dbg_data, ifc.rd_busy} !== {{4{32'hDEADBEEF}}, 3'b000})
      $display("FAIL sweep_r0_writable: got rdata=%h dbg=%h busy=%b, want deadbeef everywhere",
               ifc.rdata, ifc.dbg_data, ifc.rd_busy);
    else n_pass++;

    for (int c = 0; c < 1000; c++) begin
      tick();
      ifc.we       = 1'($urandom_range(0, 1));
      ifc.waddr    = 5'($urandom_range(0, 31));
      ifc.wdata    = $urandom;
      ifc.rsv_en   = 1'($urandom_range(0, 1));
      ifc.rsv_addr = 5'($urandom_range(0, 31));
      ifc.dbg_sel  = 5'($urandom_range(0, 31));
      for (int p = 0; p < 3; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? ifc.waddr : 5'($urandom_range(0, 31));
      ifc.raddr = {ra[2], ra[1], ra[0]};
      #1;
      for (int p = 0; p < 3; p++) begin
        if (ifc.we && ifc.waddr == ra[p]) begin
          exp_rd[p*32 +: 32] = ifc.wdata;
          exp_busy[p] = 1'b0;
        end else begin
          exp_rd[p*32 +: 32] = m_regs[ra[p]];
          exp_busy[p] = m_pend[ra[p]];
        end
      end
      n_chk++;
      if (ifc.dbg_data !== m_regs[ifc.dbg_sel])
        $display("FAIL sweep_dbg c=%0d: got %h, want %h", c, ifc.dbg_data, m_regs[ifc.dbg_sel]);
      else n_pass++;
      n_chk++;
      if ({ifc.rdata, ifc.rd_busy, ifc.pending} !== {exp_rd, exp_busy, m_pend})
        $display("FAIL sweep_read c=%0d: got rdata=%h busy=%b pend=%h, want %h %b %h",
                 c, ifc.rdata, ifc.rd_busy, ifc.pending, exp_rd, exp_busy, m_pend);
      else n_pass++;
      if (ifc.we) begin
        m_regs[ifc.waddr] = ifc.wdata;
        m_pend[ifc.waddr] = 1'b0;
      end
      if (ifc.rsv_en) m_pend[ifc.rsv_addr] = 1'b1;
    end
    tick();
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_bypass();
    test_scoreboard();
    test_same_edge();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
